// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug controller: command opcodes,
// controller states and the layout of the state-dump stream.
package mips_dbg_pkg;

  localparam logic [2:0] CMD_LOAD  = 3'd0;
  localparam logic [2:0] CMD_RUN   = 3'd1;
  localparam logic [2:0] CMD_STEP  = 3'd2;
  localparam logic [2:0] CMD_DUMP  = 3'd3;
  localparam logic [2:0] CMD_CLEAR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_STEP,
    ST_DUMP
  } state_e;

  localparam int         DUMP_LEN    = 34;
  localparam int         NB_BEAT     = 6;
  localparam logic [5:0] BEAT_PC     = 6'd0;
  localparam logic [5:0] BEAT_REG0   = 6'd1;
  localparam logic [5:0] BEAT_REG31  = 6'd32;
  localparam logic [5:0] BEAT_CYCLES = 6'd33;

  // Register index shown during a beat; beats outside r0..r31 read index 0.
  function automatic logic [4:0] beat_reg_index(input logic [5:0] beat);
    if (beat >= BEAT_REG0 && beat <= BEAT_REG31) begin
      beat_reg_index = 5'(beat - BEAT_REG0);
    end else begin
      beat_reg_index = 5'd0;
    end
  endfunction

endpackage

// File: rtl/mips_dbg_dump_seq.sv
// Streams PC, r0..r31 and the cycle count as a 34-beat valid/ready burst.
// The output word is registered and only reloaded after a handshake.
module mips_dbg_dump_seq
  import mips_dbg_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_reg_data,
  input  logic [31:0]        i_cycles,
  output logic [NB_REG-1:0]  o_reg_addr,
  output logic               o_dump_valid,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_last,
  input  logic               i_dump_ready,
  output logic               o_done
);

  logic [NB_BEAT-1:0] beat_q, beat_d;
  logic [NB_BEAT-1:0] src_beat;
  logic               valid_q, valid_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_DATA-1:0] src_data;
  logic               handshake;
  logic               at_last;

  assign handshake = valid_q && i_dump_ready;
  assign at_last   = (beat_q == BEAT_CYCLES);

  // The beat being fetched is the first one on entry, otherwise the successor.
  assign src_beat   = i_start ? BEAT_PC : (beat_q + 6'd1);
  assign o_reg_addr = NB_REG'(beat_reg_index(src_beat));

  always_comb begin
    src_data = i_reg_data;
    if (src_beat == BEAT_PC) begin
      src_data = NB_DATA'(i_pc);
    end else if (src_beat == BEAT_CYCLES) begin
      src_data = NB_DATA'(i_cycles);
    end
  end

  always_comb begin
    beat_d  = beat_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (i_start) begin
      beat_d  = BEAT_PC;
      valid_d = 1'b1;
      data_d  = src_data;
    end else if (handshake) begin
      if (at_last) begin
        beat_d  = BEAT_PC;
        valid_d = 1'b0;
        data_d  = '0;
      end else begin
        beat_d = src_beat;
        data_d = src_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      beat_q  <= BEAT_PC;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_dump_valid = valid_q;
  assign o_dump_data  = data_q;
  assign o_dump_last  = valid_q && at_last;
  assign o_done       = handshake && at_last;

endmodule

// File: rtl/mips_debug_ctrl.sv
// Debug sequencer in front of top_mips: loads imem, runs or single-steps the
// pipeline, and hands state dumps to the dump sequencer.
module mips_debug_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_CMD     = 3,
  parameter int IMEM_DEPTH = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [NB_CMD-1:0]  i_cmd,
  input  logic [NB_DATA-1:0] i_cmd_data,
  output logic               o_cmd_ready,
  output logic               o_cmd_error,
  output logic               o_enable,
  output logic               o_write,
  output logic [NB_ADDR-1:0] o_address,
  output logic [NB_DATA-1:0] o_instruction,
  input  logic               i_halt,
  input  logic [NB_ADDR-1:0] i_pc,
  output logic [NB_REG-1:0]  o_reg_addr,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic               o_dump_valid,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_last,
  input  logic               i_dump_ready,
  output logic               o_halted
);

  localparam int PTR_W = $clog2(IMEM_DEPTH + 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [31:0]        cycles_q, cycles_d;
  logic               err_q, err_d;
  logic               halted_q;
  logic               accept;
  logic               ptr_full;
  logic               dump_start;
  logic               dump_done;

  assign accept     = i_cmd_valid && (state_q == ST_IDLE);
  assign ptr_full   = (ptr_q == PTR_W'(IMEM_DEPTH));
  assign dump_start = accept && (i_cmd == NB_CMD'(CMD_DUMP));

  // A retired HALT gates the pipeline immediately, even in the cycle it appears.
  assign o_enable = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !i_halt;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    instr_d  = instr_q;
    cycles_d = cycles_q;
    err_d    = 1'b0;
    if (o_enable) begin
      cycles_d = cycles_q + 32'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (i_cmd)
            NB_CMD'(CMD_LOAD): begin
              if (ptr_full) begin
                err_d = 1'b1;
              end else begin
                state_d = ST_LOAD;
                instr_d = i_cmd_data;
              end
            end
            NB_CMD'(CMD_RUN):   state_d = ST_RUN;
            NB_CMD'(CMD_STEP):  state_d = ST_STEP;
            NB_CMD'(CMD_DUMP):  state_d = ST_DUMP;
            NB_CMD'(CMD_CLEAR): begin
              ptr_d    = '0;
              cycles_d = '0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        ptr_d   = ptr_q + PTR_W'(1);
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (i_halt) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: state_d = ST_IDLE;
      ST_DUMP: begin
        if (dump_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      instr_q  <= '0;
      cycles_q <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      instr_q  <= instr_d;
      cycles_q <= cycles_d;
      err_q    <= err_d;
      halted_q <= i_halt;
    end
  end

  // A STEP that lands on a halted pipeline is reported in its own cycle.
  assign o_cmd_error   = err_q || ((state_q == ST_STEP) && i_halt);
  assign o_cmd_ready   = (state_q == ST_IDLE);
  assign o_write       = (state_q == ST_LOAD);
  assign o_address     = (state_q == ST_LOAD) ? (NB_ADDR'(ptr_q) << 2) : '0;
  assign o_instruction = (state_q == ST_LOAD) ? instr_q : '0;
  assign o_halted      = halted_q;

  mips_dbg_dump_seq #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR),
    .NB_REG (NB_REG)
  ) u_dump_seq (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (dump_start),
    .i_pc        (i_pc),
    .i_reg_data  (i_reg_data),
    .i_cycles    (cycles_q),
    .o_reg_addr  (o_reg_addr),
    .o_dump_valid(o_dump_valid),
    .o_dump_data (o_dump_data),
    .o_dump_last (o_dump_last),
    .i_dump_ready(i_dump_ready),
    .o_done      (dump_done)
  );

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl with a small imem (depth 2) and a
// bench-side register file / PC standing in for the pipeline.
module tb_mips_debug_ctrl;

  localparam int DEPTH = 2;
  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_RUN   = 3'd1;
  localparam logic [2:0] OP_STEP  = 3'd2;
  localparam logic [2:0] OP_DUMP  = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic [2:0]  cmd;
  logic [31:0] cmdData;
  logic        cmdReady;
  logic        cmdError;
  logic        enable;
  logic        write;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        halt;
  logic [31:0] tbPc;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        dumpValid;
  logic [31:0] dumpData;
  logic        dumpLast;
  logic        dumpReady;
  logic        halted;

  logic [31:0] regFile [32];
  int          assertCount = 0;
  int          failCount   = 0;
  int          modelPtr    = 0;
  logic [31:0] modelCycles = 32'd0;

  assign regData = regFile[regAddr];

  always #5 clk = ~clk;

  mips_debug_ctrl #(
    .NB_DATA(32), .NB_ADDR(32), .NB_REG(5), .NB_CMD(3), .IMEM_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cmd_valid(cmdValid), .i_cmd(cmd), .i_cmd_data(cmdData),
    .o_cmd_ready(cmdReady), .o_cmd_error(cmdError),
    .o_enable(enable), .o_write(write), .o_address(address),
    .o_instruction(instruction),
    .i_halt(halt), .i_pc(tbPc),
    .o_reg_addr(regAddr), .i_reg_data(regData),
    .o_dump_valid(dumpValid), .o_dump_data(dumpData), .o_dump_last(dumpLast),
    .i_dump_ready(dumpReady), .o_halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for a single cycle; caller guarantees the DUT is idle.
  task automatic sendCmd(input logic [2:0] c, input logic [31:0] d);
    cmdValid = 1'b1;
    cmd      = c;
    cmdData  = d;
    tick();
    cmdValid = 1'b0;
  endtask

  task automatic doLoad(input logic [31:0] d);
    sendCmd(OP_LOAD, d);
    if (modelPtr < DEPTH) begin
      assertCount++;
      if (write !== 1'b1) begin failCount++; $display("[TB] FAIL load_write: got %b expected 1", write); end
      assertCount++;
      if (address !== 32'(modelPtr * 4)) begin failCount++; $display("[TB] FAIL load_addr: got %h expected %h", address, 32'(modelPtr * 4)); end
      assertCount++;
      if (instruction !== d) begin failCount++; $display("[TB] FAIL load_data: got %h expected %h", instruction, d); end
      assertCount++;
      if (cmdReady !== 1'b0 || enable !== 1'b0) begin failCount++; $display("[TB] FAIL load_busy: ready %b enable %b expected 0 0", cmdReady, enable); end
      modelPtr++;
    end else begin
      assertCount++;
      if (write !== 1'b0 || cmdError !== 1'b1) begin failCount++; $display("[TB] FAIL load_reject: write %b error %b expected 0 1", write, cmdError); end
    end
    tick();
    assertCount++;
    if (write !== 1'b0 || cmdError !== 1'b0 || cmdReady !== 1'b1) begin
      failCount++; $display("[TB] FAIL load_done: write %b error %b ready %b expected 0 0 1", write, cmdError, cmdReady);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmdValid = 1'b0; cmd = '0; cmdData = '0; halt = 1'b0; dumpReady = 1'b0; tbPc = '0;
    for (int i = 0; i < 32; i++) regFile[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    assertCount++;
    if ({cmdReady, cmdError, enable, write, dumpValid, dumpLast, halted} !== 7'b1000000) begin
      failCount++; $display("[TB] FAIL reset_flags: got %b expected 1000000", {cmdReady, cmdError, enable, write, dumpValid, dumpLast, halted});
    end
    assertCount++;
    if (address !== 32'd0 || instruction !== 32'd0 || dumpData !== 32'd0) begin
      failCount++; $display("[TB] FAIL reset_buses: addr %h instr %h dump %h expected 0", address, instruction, dumpData);
    end
  endtask

  task automatic test_load();
    doLoad(32'h00231020);
    doLoad(32'h00000000);
  endtask

  task automatic test_load_full();
    doLoad($urandom);
    doLoad($urandom);
    sendCmd(OP_CLEAR, 32'd0);
    modelPtr = 0;
    modelCycles = 32'd0;
    assertCount++;
    if (cmdReady !== 1'b1 || write !== 1'b0 || cmdError !== 1'b0) begin
      failCount++; $display("[TB] FAIL clear: ready %b write %b error %b expected 1 0 0", cmdReady, write, cmdError);
    end
    doLoad($urandom);
  endtask

  task automatic test_run(input int k);
    int  cnt = 0;
    logic overlap = 1'b0;
    halt = 1'b0;
    sendCmd(OP_RUN, 32'd0);
    for (int i = 0; i < k; i++) begin
      if (enable === 1'b1) cnt++;
      if (enable === 1'b1 && write === 1'b1) overlap = 1'b1;
      tick();
    end
    halt = 1'b1;
    #1;
    assertCount++;
    if (enable !== 1'b0 || cmdReady !== 1'b0) begin failCount++; $display("[TB] FAIL run_halt_cycle: enable %b ready %b expected 0 0", enable, cmdReady); end
    tick();
    assertCount++;
    if (cnt != k || overlap) begin failCount++; $display("[TB] FAIL run_enabled: got %0d cycles overlap %b expected %0d 0", cnt, overlap, k); end
    assertCount++;
    if (cmdReady !== 1'b1 || halted !== 1'b1) begin failCount++; $display("[TB] FAIL run_exit: ready %b halted %b expected 1 1", cmdReady, halted); end
    modelCycles += 32'(k);
    halt = 1'b0;
  endtask

  task automatic test_run_halted();
    halt = 1'b1;
    tick();
    sendCmd(OP_RUN, 32'd0);
    assertCount++;
    if (enable !== 1'b0 || cmdReady !== 1'b0) begin failCount++; $display("[TB] FAIL run_halted: enable %b ready %b expected 0 0", enable, cmdReady); end
    tick();
    assertCount++;
    if (enable !== 1'b0 || cmdReady !== 1'b1) begin failCount++; $display("[TB] FAIL run_halted_exit: enable %b ready %b expected 0 1", enable, cmdReady); end
    halt = 1'b0;
  endtask

  task automatic test_step(input int n);
    halt = 1'b0;
    for (int i = 0; i < n; i++) begin
      sendCmd(OP_STEP, 32'd0);
      assertCount++;
      if (enable !== 1'b1 || cmdError !== 1'b0 || write !== 1'b0) begin failCount++; $display("[TB] FAIL step_pulse: enable %b error %b write %b expected 1 0 0", enable, cmdError, write); end
      tick();
      assertCount++;
      if (enable !== 1'b0 || cmdReady !== 1'b1) begin failCount++; $display("[TB] FAIL step_end: enable %b ready %b expected 0 1", enable, cmdReady); end
      modelCycles += 32'd1;
    end
  endtask

  task automatic test_step_halted();
    halt = 1'b1;
    sendCmd(OP_STEP, 32'd0);
    assertCount++;
    if (enable !== 1'b0 || cmdError !== 1'b1) begin failCount++; $display("[TB] FAIL step_halted: enable %b error %b expected 0 1", enable, cmdError); end
    tick();
    assertCount++;
    if (cmdError !== 1'b0 || cmdReady !== 1'b1) begin failCount++; $display("[TB] FAIL step_halted_end: error %b ready %b expected 0 1", cmdError, cmdReady); end
    halt = 1'b0;
  endtask

  task automatic test_unknown();
    for (int op = 5; op < 8; op++) begin
      sendCmd(3'(op), $urandom);
      assertCount++;
      if (cmdError !== 1'b1 || cmdReady !== 1'b1 || write !== 1'b0 || enable !== 1'b0) begin
        failCount++; $display("[TB] FAIL unknown_op%0d: error %b ready %b write %b enable %b expected 1 1 0 0", op, cmdError, cmdReady, write, enable);
      end
      tick();
      assertCount++;
      if (cmdError !== 1'b0) begin failCount++; $display("[TB] FAIL unknown_pulse%0d: error %b expected 0", op, cmdError); end
    end
  endtask

  // mode 0: ready alternates 1/0; mode 1: ready random.
  task automatic test_dump(input int mode);
    logic [31:0] expq [34];
    logic [31:0] held = '0;
    logic        stalled = 1'b0;
    int          beat = 0;
    expq[0] = tbPc;
    for (int i = 0; i < 32; i++) expq[i + 1] = regFile[i];
    expq[33] = modelCycles;
    sendCmd(OP_DUMP, 32'd0);
    for (int cyc = 0; cyc < 500 && beat < 34; cyc++) begin
      dumpReady = (mode == 0) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      assertCount++;
      if (dumpValid !== 1'b1 || enable !== 1'b0) begin failCount++; $display("[TB] FAIL dump_active beat %0d: valid %b enable %b expected 1 0", beat, dumpValid, enable); end
      if (stalled) begin
        assertCount++;
        if (dumpData !== held) begin failCount++; $display("[TB] FAIL dump_stable beat %0d: got %h expected %h", beat, dumpData, held); end
      end
      assertCount++;
      if (dumpLast !== (beat == 33)) begin failCount++; $display("[TB] FAIL dump_last beat %0d: got %b expected %b", beat, dumpLast, beat == 33); end
      if (dumpValid && dumpReady) begin
        assertCount++;
        if (dumpData !== expq[beat]) begin failCount++; $display("[TB] FAIL dump_data beat %0d: got %h expected %h", beat, dumpData, expq[beat]); end
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = dumpData;
      end
      tick();
    end
    dumpReady = 1'b0;
    assertCount++;
    if (beat != 34) begin failCount++; $display("[TB] FAIL dump_count: got %0d beats expected 34", beat); end
    assertCount++;
    if (dumpValid !== 1'b0 || cmdReady !== 1'b1) begin failCount++; $display("[TB] FAIL dump_exit: valid %b ready %b expected 0 1", dumpValid, cmdReady); end
  endtask

  task automatic test_reset_mid();
    int beat = 0;
    dumpReady = 1'b1;
    sendCmd(OP_DUMP, 32'd0);
    for (int cyc = 0; cyc < 20 && beat < 5; cyc++) begin
      if (dumpValid && dumpReady) beat++;
      tick();
    end
    assertCount++;
    if (dumpValid !== 1'b1 || dumpData !== regFile[4]) begin failCount++; $display("[TB] FAIL dump_beat5: valid %b data %h expected 1 %h", dumpValid, dumpData, regFile[4]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dumpReady = 1'b0;
    assertCount++;
    if (dumpValid !== 1'b0 || cmdReady !== 1'b1 || dumpLast !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_dump: valid %b ready %b last %b expected 0 1 0", dumpValid, cmdReady, dumpLast);
    end
    modelPtr = 0;
    modelCycles = 32'd0;
    halt = 1'b0;
    sendCmd(OP_RUN, 32'd0);
    tick(); tick();
    assertCount++;
    if (enable !== 1'b1) begin failCount++; $display("[TB] FAIL run_before_reset: enable %b expected 1", enable); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    assertCount++;
    if (enable !== 1'b0 || cmdReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_run: enable %b ready %b expected 0 1", enable, cmdReady); end
    doLoad($urandom);
    test_dump(1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 4))
        0: doLoad($urandom);
        1: test_run(int'($urandom_range(1, 12)));
        2: test_step(1);
        3: begin
          sendCmd(OP_CLEAR, 32'd0);
          modelPtr = 0;
          modelCycles = 32'd0;
          assertCount++;
          if (cmdReady !== 1'b1) begin failCount++; $display("[TB] FAIL rand_clear: ready %b expected 1", cmdReady); end
        end
        default: test_unknown();
      endcase
    end
    tbPc = $urandom;
    for (int i = 1; i < 32; i++) regFile[i] = $urandom;
    test_dump(1);
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_full();
    test_run(7);
    test_run_halted();
    test_step(3);
    test_step_halted();
    test_unknown();
    tbPc = 32'h10;
    regFile[0] = 32'd0;
    for (int i = 1; i < 32; i++) regFile[i] = $urandom;
    regFile[2] = 32'd4;
    test_dump(0);
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
    $fatal(1);
  end

endmodule
